hex_scan_display: RTL and testbench

- Parametrised successor to the single-digit hex-to-7-segment decoder.
- Drives NUM_DIGITS common-anode/cathode digits through one shared segment bus by time-multiplexed scanning.
- Latches a hex value on a load strobe and decodes each nibble with the team's standard a..g patterns.
- Adds per-digit blanking, decimal points, leading-zero suppression, an anti-ghosting gap and whole-display blink.
- Sits between CPU debug/IO registers and the board's seven-segment pins.

---
 rtl/hex_scan_display.sv | 157 +++++++++++++++
 tb/tb_hex_scan_display.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/hex_scan_display.sv
// Multiplexed NUM_DIGITS-digit hex display driver: latched shadow data, per-digit
// blanking, decimal points, leading-zero suppression, anti-ghost gap and blink.
`timescale 1ns/1ps
module hex_scan_display #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_blank,
  input  logic                    blink_en,
  output logic [0:6]              seg,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int CW = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
  localparam int IW = (NUM_DIGITS   > 1) ? $clog2(NUM_DIGITS)   : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic POL_LOW = (ACTIVE_LOW != 0);

  // Team standard a..g patterns, active-low.
  function automatic logic [0:6] decode_al(input logic [3:0] n);
    case (n)
      4'h0:    decode_al = 7'b0000001;
      4'h1:    decode_al = 7'b1001111;
      4'h2:    decode_al = 7'b0010010;
      4'h3:    decode_al = 7'b0000110;
      4'h4:    decode_al = 7'b1001100;
      4'h5:    decode_al = 7'b0100100;
      4'h6:    decode_al = 7'b0100000;
      4'h7:    decode_al = 7'b0001111;
      4'h8:    decode_al = 7'b0000000;
      4'h9:    decode_al = 7'b0000100;
      4'hA:    decode_al = 7'b0001000;
      4'hB:    decode_al = 7'b1100000;
      4'hC:    decode_al = 7'b0110001;
      4'hD:    decode_al = 7'b1000010;
      4'hE:    decode_al = 7'b0110000;
      4'hF:    decode_al = 7'b0111000;
      default: decode_al = 7'b0100011;
    endcase
  endfunction

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [FW-1:0]           frame_q, frame_d;
  logic                    phase_q, phase_d;
  logic [4*NUM_DIGITS-1:0] val_q, val_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [0:6]              seg_q, seg_d;
  logic                    dpo_q, dpo_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    tick_q, tick_d;

  logic                    cnt_wrap, idx_wrap, frame_wrap, hi_zero, dark;
  logic [NUM_DIGITS-1:0]   lz_sup, an_hi;
  logic [0:6]              seg_hi;
  logic                    dp_hi;
  logic [3:0]              nib;

  always_comb begin
    cnt_wrap   = (cnt_q == CW'(REFRESH_DIV - 1));
    idx_wrap   = (idx_q == IW'(NUM_DIGITS - 1));
    frame_wrap = cnt_wrap && idx_wrap;

    cnt_d  = cnt_wrap ? '0 : cnt_q + 1'b1;
    idx_d  = idx_q;
    if (cnt_wrap) idx_d = idx_wrap ? '0 : idx_q + 1'b1;
    tick_d = frame_wrap;

    // Blink state advances on the same edge that raises frame_tick.
    frame_d = frame_q;
    phase_d = phase_q;
    if (!blink_en) begin
      frame_d = '0;
      phase_d = 1'b0;
    end else if (frame_wrap) begin
      if (frame_q == FW'(BLINK_FRAMES - 1)) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end

    val_d   = load ? value      : val_q;
    dp_d    = load ? dp_in      : dp_q;
    blank_d = load ? blank_mask : blank_q;

    // Scan from the top digit down; a digit is suppressible while everything above it is zero.
    hi_zero = 1'b1;
    lz_sup  = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      hi_zero = hi_zero && (val_q[4*(NUM_DIGITS-1-i) +: 4] == 4'h0);
      if (i != NUM_DIGITS - 1) lz_sup[NUM_DIGITS-1-i] = hi_zero;
    end

    nib  = val_q[{idx_q, 2'b00} +: 4];
    dark = cnt_wrap || blank_q[idx_q] || (lz_blank && lz_sup[idx_q]) || (blink_en && phase_q);

    an_hi  = '0;
    seg_hi = '0;
    dp_hi  = 1'b0;
    if (!dark) begin
      an_hi[idx_q] = 1'b1;
      seg_hi       = ~decode_al(nib);
      dp_hi        = dp_q[idx_q];
    end

    an_d  = POL_LOW ? ~an_hi  : an_hi;
    seg_d = POL_LOW ? ~seg_hi : seg_hi;
    dpo_d = POL_LOW ? ~dp_hi  : dp_hi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      phase_q <= 1'b0;
      val_q   <= '0;
      dp_q    <= '0;
      blank_q <= '0;
      seg_q   <= POL_LOW ? '1 : '0;
      dpo_q   <= POL_LOW;
      an_q    <= POL_LOW ? '1 : '0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      phase_q <= phase_d;
      val_q   <= val_d;
      dp_q    <= dp_d;
      blank_q <= blank_d;
      seg_q   <= seg_d;
      dpo_q   <= dpo_d;
      an_q    <= an_d;
      tick_q  <= tick_d;
    end
  end

  assign seg        = seg_q;
  assign dp_out     = dpo_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// Directed bench for hex_scan_display with 4 digits, 4-cycle slots, 2-frame blink.
`timescale 1ns/1ps
module tb_hex_scan_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_mask = '0;
  logic        lz_blank = 1'b0;
  logic        blink_en = 1'b0;
  logic [0:6]  seg;
  logic        dp_out;
  logic [3:0]  an;
  logic        frame_tick;

  int errors = 0;
  int checks = 0;

  localparam logic [0:6] DK = 7'b1111111;
  localparam logic [3:0][3:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
  localparam logic [3:0][3:0] AN_D0  = {4'b1111, 4'b1111, 4'b1111, 4'b1110};
  localparam logic [3:0][3:0] AN_OFF = {4'b1111, 4'b1111, 4'b1111, 4'b1111};

  logic [0:6] hex_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  hex_scan_display #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .BLINK_FRAMES(2),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value     (value),
    .load      (load),
    .dp_in     (dp_in),
    .blank_mask(blank_mask),
    .lz_blank  (lz_blank),
    .blink_en  (blink_en),
    .seg       (seg),
    .dp_out    (dp_out),
    .an        (an),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Cycle j (1..16) counts output updates after a frame wrap; slot = (j-1)/4, last cycle of each slot dark.
  task automatic check_cycles(input int first, input int last, input logic [3:0][3:0] ean,
                              input logic [3:0][0:6] es, input logic [3:0] edp);
    for (int j = first; j <= last; j++) begin
      int d, p;
      @(negedge clk);
      d = (j - 1) / 4;
      p = (j - 1) % 4;
      if (p == 3) begin
        chk($sformatf("gap_an j%0d", j), 32'(an), 32'hF);
        chk($sformatf("gap_seg j%0d", j), 32'(seg), 32'(DK));
        chk($sformatf("gap_dp j%0d", j), 32'(dp_out), 32'd1);
      end else begin
        chk($sformatf("an j%0d", j), 32'(an), 32'(ean[d]));
        chk($sformatf("seg j%0d", j), 32'(seg), 32'(es[d]));
        chk($sformatf("dp j%0d", j), 32'(dp_out), 32'(edp[d]));
      end
      chk($sformatf("tick j%0d", j), 32'(frame_tick), 32'(j == 16));
    end
  endtask

  task automatic sync_frame();
    int n = 0;
    while (frame_tick !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("sync_tick", 32'(frame_tick), 32'd1);
  endtask

  task automatic load_vec(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bm);
    value      = v;
    dp_in      = dp;
    blank_mask = bm;
    load       = 1'b1;
    @(negedge clk);
    load = 1'b0;
    sync_frame();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'(DK));
    chk("rst_dp", 32'(dp_out), 32'd1);
    chk("rst_tick", 32'(frame_tick), 32'd0);
    rst_n = 1'b1;
    check_cycles(1, 16, AN_ALL, {4{hex_tab[0]}}, 4'b1111);

    load_vec(16'h1234, 4'b0000, 4'b0000);
    check_cycles(1, 16, AN_ALL, {hex_tab[1], hex_tab[2], hex_tab[3], hex_tab[4]}, 4'b1111);

    // Asynchronous reset while digit 0 is lit.
    @(negedge clk);
    chk("pre_rst_an", 32'(an), 32'hE);
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", 32'(an), 32'hF);
    chk("async_seg", 32'(seg), 32'(DK));
    chk("async_dp", 32'(dp_out), 32'd1);
    chk("async_tick", 32'(frame_tick), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_cycles(1, 16, AN_ALL, {4{hex_tab[0]}}, 4'b1111);

    lz_blank = 1'b1;
    load_vec(16'h0050, 4'b0010, 4'b0000);
    check_cycles(1, 16, {4'b1111, 4'b1111, 4'b1101, 4'b1110}, {DK, DK, hex_tab[5], hex_tab[0]}, 4'b1101);
    load_vec(16'h0000, 4'b0000, 4'b0000);
    check_cycles(1, 16, AN_D0, {DK, DK, DK, hex_tab[0]}, 4'b1111);
    lz_blank = 1'b0;

    for (int unsigned k = 0; k < 16; k++) begin
      load_vec({12'h888, 4'(k)}, 4'b0000, 4'b1110);
      check_cycles(1, 16, AN_D0, {DK, DK, DK, hex_tab[k]}, 4'b1111);
    end

    load_vec(16'h1234, 4'b0000, 4'b0000);
    blink_en = 1'b1;
    check_cycles(1, 16, AN_ALL, {hex_tab[1], hex_tab[2], hex_tab[3], hex_tab[4]}, 4'b1111);
    check_cycles(1, 16, AN_ALL, {hex_tab[1], hex_tab[2], hex_tab[3], hex_tab[4]}, 4'b1111);
    check_cycles(1, 16, AN_OFF, {4{DK}}, 4'b1111);
    check_cycles(1, 5, AN_OFF, {4{DK}}, 4'b1111);
    blink_en = 1'b0;
    check_cycles(6, 16, AN_ALL, {hex_tab[1], hex_tab[2], hex_tab[3], hex_tab[4]}, 4'b1111);
    check_cycles(1, 16, AN_ALL, {hex_tab[1], hex_tab[2], hex_tab[3], hex_tab[4]}, 4'b1111);

    // Load lands in the cycle frame_tick is high; its capture edge still shows the old digit.
    value = 16'hABCD;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("wrap_an j1", 32'(an), 32'hE);
    check_cycles(2, 16, AN_ALL, {hex_tab[10], hex_tab[11], hex_tab[12], hex_tab[13]}, 4'b1111);
    check_cycles(1, 16, AN_ALL, {hex_tab[10], hex_tab[11], hex_tab[12], hex_tab[13]}, 4'b1111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
